cache_arbiter: RTL
==================

# cache_arbiter

Two-requester arbiter that shares the single line-wide physical memory port between the instruction cache and the data cache. Each cache's miss path (writeback/fetch) issues level-held line requests; the arbiter grants one requester at a time, forwards its request to memory, and steers the memory response back. It sits between the two cache controllers and the cacheline adaptor / main memory model.

## Interface
- s_addr, 32: address width
- s_line, 256: line width in bits
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_read  in  1  I-cache line read request, held until i_resp
- i_addr  in  s_addr  I-cache line address, stable while i_read
- i_rdata  out  s_line  read line to I-cache (mem_rdata passthrough)
- i_resp  out  1  one-cycle completion pulse to I-cache
- d_read  in  1  D-cache line read request, held until d_resp
- d_write  in  1  D-cache line writeback request, held until d_resp
- d_addr  in  s_addr  D-cache line address, stable while request held
- d_wdata  in  s_line  D-cache writeback line
- d_rdata  out  s_line  read line to D-cache (mem_rdata passthrough)
- d_resp  out  1  one-cycle completion pulse to D-cache
- mem_read  out  1  memory line read
- mem_write  out  1  memory line write
- mem_addr  out  s_addr  memory address
- mem_wdata  out  s_line  memory write line
- mem_rdata  in  s_line  memory read line
- mem_resp  in  1  memory completion pulse
- conflict_count  out  32  cycles in IDLE with both caches requesting

## Operation
- States: IDLE, SERVE_I, SERVE_D. Register last_grant (I or D).
- IDLE: no memory request driven. If only i_read -> SERVE_I. If only d_read|d_write -> SERVE_D. If both: grant the requester not equal to last_grant (round-robin); if both pending, increment conflict_count. last_grant updated on entry to SERVE_x.
- SERVE_I: mem_read=1, mem_write=0, mem_addr=i_addr. On mem_resp: i_resp=1 same cycle, next state IDLE.
- SERVE_D: mem_addr=d_addr, mem_wdata=d_wdata; mem_write=d_write, mem_read=d_read & ~d_write (d_write wins if both asserted). On mem_resp: d_resp=1 same cycle, next state IDLE.
- i_rdata and d_rdata are both driven from mem_rdata unconditionally; only the resp pulses are steered.
- mem_resp in IDLE: ignored, no resp pulse.
- Requester dropping its request while granted: illegal; arbiter stays in SERVE_x until mem_resp, then pulses that requester's resp anyway.
- Outside SERVE_x: mem_addr, mem_wdata = 0.
- conflict_count wraps at 2^32.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, last_grant=I (D wins first conflict), conflict_count=0; all outputs 0 except rdata passthroughs. Reset mid-service abandons the transaction immediately; no resp is produced.
- Request seen in IDLE at cycle t -> mem_read/mem_write asserted from cycle t+1, registered state.
- Response: mem_resp at cycle r -> x_resp at r (combinational), IDLE at r+1; earliest next grant is r+2 memory-visible. Minimum occupancy per transaction 2 cycles + memory latency.
- A D-cache writeback followed by fetch is two separate grants; a pending I request is served between them if it arrived first per round-robin.
- mem_read and mem_write are never both 1; at most one of i_resp/d_resp is 1 in any cycle.

## Test plan
- Lone I read: i_read=1, i_addr=0x0000_0040, memory returns 0xAA.. after 3 cycles -> mem_read from t+1, mem_addr=0x40, i_resp one cycle with i_rdata=0xAA.., d_resp stays 0.
- Lone D writeback: d_write=1, d_addr=0x1000, d_wdata=0x55.. -> mem_write=1, mem_wdata=0x55.., mem_read=0, d_resp pulse on mem_resp.
- Simultaneous after reset: i_read and d_read both rise at t -> SERVE_D first, conflict_count=1; after d_resp, SERVE_I; next simultaneous conflict grants D again (last_grant=I) and conflict_count=2.
- D write then read with I pending: D writeback granted, I raised mid-service -> after d_resp, I granted before D's fetch.
- Spurious mem_resp in IDLE -> no i_resp/d_resp, state unchanged; d_read&d_write both high -> mem_write=1, mem_read=0.
- rst_n pulsed low during SERVE_I -> mem_read=0 immediately, conflict_count=0, no i_resp; fresh i_read afterward completes normally.

Source files
------------

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the I-cache and D-cache miss paths.
// Requests are level-held until the steered one-cycle resp pulse.
//
// state   | meaning
// IDLE    | no memory request driven; arbitrate pending requests
// SERVE_I | forwarding I-cache line read until mem_resp
// SERVE_D | forwarding D-cache read/writeback until mem_resp
module cache_arbiter #(
    parameter int S_ADDR = 32,
    parameter int S_LINE = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [S_ADDR-1:0] i_addr,
    output logic [S_LINE-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [S_ADDR-1:0] d_addr,
    input  logic [S_LINE-1:0] d_wdata,
    output logic [S_LINE-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [S_ADDR-1:0] mem_addr,
    output logic [S_LINE-1:0] mem_wdata,
    input  logic [S_LINE-1:0] mem_rdata,
    input  logic              mem_resp,
    output logic [31:0]       conflict_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_grant_d_q;   // 1: D was granted last, 0: I was granted last
    logic   conflict;

    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            last_grant_d_q <= 1'b0;
            conflict_count <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && state_d == SERVE_I) begin
                last_grant_d_q <= 1'b0;
            end else if (state_q == IDLE && state_d == SERVE_D) begin
                last_grant_d_q <= 1'b1;
            end
            if (conflict) begin
                conflict_count <= conflict_count + 32'd1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_resp    = 1'b0;
        d_resp    = 1'b0;
        conflict  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_read && (d_read || d_write)) begin
                    conflict = 1'b1;
                    state_d  = last_grant_d_q ? SERVE_I : SERVE_D;
                end else if (i_read) begin
                    state_d = SERVE_I;
                end else if (d_read || d_write) begin
                    state_d = SERVE_D;
                end
            end
            SERVE_I: begin
                mem_read = 1'b1;
                mem_addr = i_addr;
                if (mem_resp) begin
                    i_resp  = 1'b1;
                    state_d = IDLE;
                end
            end
            SERVE_D: begin
                // a writeback takes priority if the D-cache raises both
                mem_write = d_write;
                mem_read  = d_read & ~d_write;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                if (mem_resp) begin
                    d_resp  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
